cpu_ctrl: RTL
=============

Name: cpu_ctrl

Overview:
Instruction-sequencing controller that drives the 16-bit register/ALU datapath from the opposite side of its control interface.
- Fetches instructions from a 9-bit-address memory and holds them in an instruction register (IR).
- Decodes each instruction and steps a multicycle FSM that issues the datapath control signals: register select, load enables, mux selects, ALU op, shift, writeback.
- Owns the PC and the data-address register for loads and stores.

Parameters:
ADDR_W, 9, PC/memory address width (datapath PC input is 9 bits).
RESET_PC, 9'h000, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
mem_rdata  in  16  memory read data, valid in cycle after mem_cmd=READ issued
datapath_out  in  16  datapath C register (load/store address, store data source)
Z_out  in  3  datapath status {V,N,Z} = [2:1:0]
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
mem_addr  out  ADDR_W  PC or data-address register
readnum  out  3  register-file read select
writenum  out  3  register-file write select
write  out  1  register-file write enable
vsel  out  4  one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
loada, loadb, loadc, loads  out  1 each  datapath load enables
asel, bsel  out  1 each  1 = zero A / sximm5 B
shift  out  2  shifter op
ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B
sximm8  out  16  sign-extended IR[7:0]
sximm5  out  16  sign-extended IR[4:0]
PC  out  ADDR_W  current PC
halted  out  1  FSM in HALT

Behaviour:
- Reset is asynchronous, active-low.
  - PC=RESET_PC, IR=0, DA=0, state=RST.
  - All enables 0, vsel=0000, mem_cmd=NONE, halted=0.
  - Reset mid-instruction aborts it; no further write or mem_cmd is issued.
- IR fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
- Decode outputs:
  - sximm8 and sximm5 are combinational from IR.
  - shift=sh in COMPUTE for ALU/MOV-reg ops, else 00.
  - ALUop=op for opcode 101, else 00.
- Outputs are Moore, decoded from state plus IR. Each state lasts one cycle.
- Fetch: RST→IF1(mem_addr=PC, READ)→IF2(READ, IR<=mem_rdata)→UPD_PC(PC<=PC+1, wraps 511→0)→DECODE.
- MOV Rn,#imm8 (110/10): WR_IMM (writenum=Rn, vsel=0100, write). 5 cycles total.
- MOV Rd,Rm{,sh} (110/00): GET_B (readnum=Rm, loadb)→COMPUTE (asel=1, ALUop=00, loadc)→WR_REG (writenum=Rd, vsel=0001, write). 7 cycles total.
- ADD/CMP/AND/MVN (101/xx): GET_A (readnum=Rn, loada)→GET_B→COMPUTE (loadc; loads=1 only for CMP)→WR_REG. CMP skips WR_REG. 8 cycles; CMP 7.
- LDR Rd,[Rn,#imm5] (011/00): GET_A→ADDR (bsel=1, ALUop=00, loadc)→LD_DA (DA<=datapath_out[8:0])→RD1 (mem_addr=DA, READ)→RD2 (READ, writenum=Rd, vsel=1000, write). 9 cycles total.
- STR Rd,[Rn,#imm5] (100/00): GET_A→ADDR→LD_DA→GET_B (readnum=Rd, loadb)→STC (asel=1, bsel=0, loadc)→WR (mem_addr=DA, WRITE; data is datapath_out). 10 cycles total.
- HALT (111): state HALT, halted=1, mem_cmd=NONE, all enables 0. Held until reset.
- Undefined opcode/op: NOP, returns to IF1. PC has already advanced.
- mem_addr = DA in RD1/RD2/WR, else PC.
- At most one of write/loada/loadb/loadc is high per cycle; loads only with loadc.

Optional Feature:
CPU_COND_BRANCH_EN
- With the macro: opcode 001, op 00, cond IR[10:8]:
  - 000 B (always)
  - 001 BEQ (Z)
  - 010 BNE (!Z)
  - 011 BLT (N!=V)
  - 100 BLE (N!=V or Z)
- Branch executes in state BR, which follows DECODE. If taken, PC <= PC + sximm8[8:0] (PC already incremented; wraps mod 2^ADDR_W). Then IF1. 5 cycles.
- Without the macro: opcode 001 is an undefined NOP.

Decomposition:
- Package cpu_pkg:
  - state enum
  - opcode/op constants
  - mem_cmd codes (MEM_NONE/MEM_READ/MEM_WRITE)
  - vsel one-hot constants
  - ALUop constants
- Sub-module instr_dec: combinational IR→fields, sximm8/sximm5, instruction class.
- FSM, PC, IR and DA stay in cpu_ctrl.

Test Plan:
- Reset, then mem returns 0xD007 (MOV R0,#7) → IF1 addr 0, then 5th cycle: write=1, writenum=0, vsel=0100, sximm8=0x0007; PC=1.
- 0xA148 (ADD R2,R1,R0,LSL#1) → readnum 1 with loada, then readnum 0 with loadb, then shift=01, ALUop=00, loadc, then writenum=2, vsel=0001, write; loads=0.
- 0xA900 (CMP R1,R0) → ALUop=01, loadc=loads=1, no write; next cycle is IF1.
- 0x6064 (LDR R3,[R0,#4]), datapath_out=0x0014 at LD_DA → bsel=1 in ADDR; RD1 mem_addr=0x014, READ; RD2 write=1, writenum=3, vsel=1000.
- 0xE000 → halted=1, mem_cmd=NONE for 20 cycles; reset_n pulse low mid-STR WR state → mem_cmd=NONE immediately, PC=0, halted=0.
- CPU_COND_BRANCH_EN: PC=5 fetches 0x21FE (BEQ -2), Z_out=001 → PC=4; Z_out=000 → PC=6.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_ctrl instruction sequencer.
// The conditional-branch decode is compiled in when CPU_COND_BRANCH_EN is defined.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPD_PC,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_WR_REG,
        S_ADDR,
        S_LD_DA,
        S_RD1,
        S_RD2,
        S_STC,
        S_WR,
        S_HALT,
        S_BR
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_MOVI,
        CLS_MOVR,
        CLS_ALU,
        CLS_CMP,
        CLS_LDR,
        CLS_STR,
        CLS_HALT,
        CLS_BR
    } cls_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [1:0]       op;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rd;
        logic [1:0]       sh;
        logic [REG_W-1:0] rm;
    } ir_t;

    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_MEM  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b00;

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// Combinational instruction decode: IR fields, sign-extended immediates, instruction class.
// Opcode 001 decodes as a branch only when CPU_COND_BRANCH_EN is defined.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] i_ir,
    output logic [REG_W-1:0]  o_rn,
    output logic [REG_W-1:0]  o_rd,
    output logic [REG_W-1:0]  o_rm,
    output logic [1:0]        o_sh,
    output logic [1:0]        o_op,
    output logic [DATA_W-1:0] o_sximm8,
    output logic [DATA_W-1:0] o_sximm5,
    output cls_t              o_cls
);

    ir_t w_ir;

    assign w_ir     = ir_t'(i_ir);
    assign o_rn     = w_ir.rn;
    assign o_rd     = w_ir.rd;
    assign o_rm     = w_ir.rm;
    assign o_sh     = w_ir.sh;
    assign o_op     = w_ir.op;
    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

    // Anything not matched below falls through as a NOP.
    always_comb begin
        o_cls = CLS_NOP;
        case (w_ir.opcode)
            OPC_MOV: begin
                if (w_ir.op == OP_MOVI)      o_cls = CLS_MOVI;
                else if (w_ir.op == OP_MOVR) o_cls = CLS_MOVR;
            end
            OPC_ALU:  o_cls = (w_ir.op == OP_CMP) ? CLS_CMP : CLS_ALU;
            OPC_LDR:  if (w_ir.op == OP_MEM) o_cls = CLS_LDR;
            OPC_STR:  if (w_ir.op == OP_MEM) o_cls = CLS_STR;
            OPC_HALT: o_cls = CLS_HALT;
`ifdef CPU_COND_BRANCH_EN
            OPC_BR:   if (w_ir.op == OP_BR && w_ir.rn <= COND_BLE) o_cls = CLS_BR;
`endif
            default:  o_cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multicycle instruction sequencer: fetch, decode and datapath control; owns PC, IR and DA.
// Define CPU_COND_BRANCH_EN to add conditional PC-relative branches (opcode 001).
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] datapath_out,
    input  logic [2:0]        Z_out,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [REG_W-1:0]  readnum,
    output logic [REG_W-1:0]  writenum,
    output logic              write,
    output logic [3:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic [ADDR_W-1:0] PC,
    output logic              halted
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_ir;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_da;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                w_sel_da;
    logic [REG_W-1:0]    w_rn;
    logic [REG_W-1:0]    w_rd;
    logic [REG_W-1:0]    w_rm;
    logic [1:0]          w_sh;
    logic [1:0]          w_op;
    cls_t                w_cls;
    logic                w_unused_ok;

    instr_dec u_dec (
        .i_ir     (r_ir),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_sh     (w_sh),
        .o_op     (w_op),
        .o_sximm8 (sximm8),
        .o_sximm5 (sximm5),
        .o_cls    (w_cls)
    );

`ifdef CPU_COND_BRANCH_EN
    logic w_br_taken;

    // Z_out is {V,N,Z}; the condition code lives in the Rn field.
    always_comb begin
        w_br_taken = 1'b0;
        case (w_rn)
            COND_B:   w_br_taken = 1'b1;
            COND_BEQ: w_br_taken = Z_out[0];
            COND_BNE: w_br_taken = ~Z_out[0];
            COND_BLT: w_br_taken = Z_out[1] ^ Z_out[2];
            COND_BLE: w_br_taken = (Z_out[1] ^ Z_out[2]) | Z_out[0];
            default:  w_br_taken = 1'b0;
        endcase
    end

    assign w_unused_ok = ^datapath_out[DATA_W-1:ADDR_W];
`else
    assign w_unused_ok = ^{datapath_out[DATA_W-1:ADDR_W], Z_out};
`endif

    always_comb begin
        w_pc_nxt = r_pc;
        if (r_state == S_UPD_PC) begin
            w_pc_nxt = r_pc + ADDR_W'(1);
        end
`ifdef CPU_COND_BRANCH_EN
        else if (r_state == S_BR && w_br_taken) begin
            w_pc_nxt = r_pc + sximm8[ADDR_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
            r_da <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (r_state == S_IF2)   r_ir <= mem_rdata;
            if (r_state == S_LD_DA) r_da <= datapath_out[ADDR_W-1:0];
        end
    end

    // Moore next-state and control decode; every state lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        mem_cmd     = MEM_NONE;
        w_sel_da    = 1'b0;
        readnum     = '0;
        writenum    = '0;
        write       = 1'b0;
        vsel        = VSEL_NONE;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = 2'b00;
        ALUop       = ALU_ADD;
        halted      = 1'b0;
        case (r_state)
            S_RST:    w_state_nxt = S_IF1;
            S_IF1: begin
                mem_cmd     = MEM_READ;
                w_state_nxt = S_IF2;
            end
            S_IF2: begin
                mem_cmd     = MEM_READ;
                w_state_nxt = S_UPD_PC;
            end
            S_UPD_PC: w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    CLS_MOVI:                            w_state_nxt = S_WR_IMM;
                    CLS_MOVR:                            w_state_nxt = S_GET_B;
                    CLS_ALU, CLS_CMP, CLS_LDR, CLS_STR:  w_state_nxt = S_GET_A;
                    CLS_HALT:                            w_state_nxt = S_HALT;
                    CLS_BR:                              w_state_nxt = S_BR;
                    default:                             w_state_nxt = S_IF1;
                endcase
            end
            S_WR_IMM: begin
                writenum    = w_rn;
                vsel        = VSEL_IMM8;
                write       = 1'b1;
                w_state_nxt = S_IF1;
            end
            S_GET_A: begin
                readnum     = w_rn;
                loada       = 1'b1;
                w_state_nxt = (w_cls == CLS_LDR || w_cls == CLS_STR) ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                readnum     = (w_cls == CLS_STR) ? w_rd : w_rm;
                loadb       = 1'b1;
                w_state_nxt = (w_cls == CLS_STR) ? S_STC : S_COMPUTE;
            end
            S_COMPUTE: begin
                loadc       = 1'b1;
                asel        = (w_cls == CLS_MOVR);
                loads       = (w_cls == CLS_CMP);
                shift       = w_sh;
                ALUop       = (w_cls == CLS_ALU || w_cls == CLS_CMP) ? w_op : ALU_ADD;
                w_state_nxt = (w_cls == CLS_CMP) ? S_IF1 : S_WR_REG;
            end
            S_WR_REG: begin
                writenum    = w_rd;
                vsel        = VSEL_C;
                write       = 1'b1;
                w_state_nxt = S_IF1;
            end
            S_ADDR: begin
                bsel        = 1'b1;
                loadc       = 1'b1;
                w_state_nxt = S_LD_DA;
            end
            S_LD_DA:  w_state_nxt = (w_cls == CLS_LDR) ? S_RD1 : S_GET_B;
            S_RD1: begin
                mem_cmd     = MEM_READ;
                w_sel_da    = 1'b1;
                w_state_nxt = S_RD2;
            end
            S_RD2: begin
                mem_cmd     = MEM_READ;
                w_sel_da    = 1'b1;
                writenum    = w_rd;
                vsel        = VSEL_MDATA;
                write       = 1'b1;
                w_state_nxt = S_IF1;
            end
            S_STC: begin
                asel        = 1'b1;
                loadc       = 1'b1;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                mem_cmd     = MEM_WRITE;
                w_sel_da    = 1'b1;
                w_state_nxt = S_IF1;
            end
            S_HALT: begin
                halted      = 1'b1;
                w_state_nxt = S_HALT;
            end
            S_BR:     w_state_nxt = S_IF1;
            default:  w_state_nxt = S_IF1;
        endcase
    end

    assign mem_addr = w_sel_da ? r_da : r_pc;
    assign PC       = r_pc;

endmodule
